// File: rtl/proc_debug_pkg.sv
// Shared types and constants for the architectural register dump unit.
package proc_debug_pkg;

    localparam int unsigned NUM_ARCH_REGS = 32;
    localparam int unsigned ARCH_W        = 5;
    localparam int unsigned PREG_W        = 7;
    localparam int unsigned DATA_W        = 32;

    localparam logic [ARCH_W:0] FULL_COUNT = (ARCH_W + 1)'(NUM_ARCH_REGS);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_Q,
        LOOKUP,
        READ,
        OUT,
        FIN
    } dump_state_t;

    typedef struct packed {
        logic [ARCH_W-1:0] arch;
        logic [PREG_W-1:0] preg;
        logic [DATA_W-1:0] data;
    } dump_beat_t;

    function automatic logic [DATA_W-1:0] rotl1(input logic [DATA_W-1:0] v);
        return {v[DATA_W-2:0], v[DATA_W-1]};
    endfunction

endpackage

// File: rtl/arch_reg_dump_unit.sv
// Debug reader: waits for the ROB to drain, then streams (arch, phys, value) beats for a window
// of architectural registers. Optional running checksum when DUMP_CHECKSUM_EN is defined.
module arch_reg_dump_unit
    import proc_debug_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [ARCH_W-1:0] first_i,
    input  logic [ARCH_W:0]   count_i,
    input  logic              abort_i,
    input  logic              rob_empty_i,
    output logic [ARCH_W-1:0] map_idx_o,
    input  logic [PREG_W-1:0] map_preg_i,
    output logic [PREG_W-1:0] prf_raddr_o,
    input  logic [DATA_W-1:0] prf_rdata_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ARCH_W-1:0] out_arch_o,
    output logic [PREG_W-1:0] out_preg_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              busy_o,
    output logic              done_o
`ifdef DUMP_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum_o
`endif
);

    dump_state_t       state_q, state_d;
    logic [ARCH_W-1:0] cur_q, cur_d;
    logic [ARCH_W:0]   rem_q, rem_d;
    logic [PREG_W-1:0] preg_q, preg_d;
    dump_beat_t        beat_q, beat_d;

    logic start_accept;
    logic beat_accept;

    assign start_accept = (state_q == IDLE) && start_i;
    assign beat_accept  = (state_q == OUT) && out_ready_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cur_q   <= '0;
            rem_q   <= '0;
            preg_q  <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            rem_q   <= rem_d;
            preg_q  <= preg_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        rem_d       = rem_q;
        preg_d      = preg_q;
        beat_d      = beat_q;
        map_idx_o   = '0;
        prf_raddr_o = '0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    cur_d   = first_i;
                    rem_d   = (count_i == '0) ? FULL_COUNT : count_i;
                    state_d = WAIT_Q;
                end
            end
            WAIT_Q: begin
                if (rob_empty_i) begin
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                map_idx_o   = cur_q;
                preg_d      = map_preg_i;
                prf_raddr_o = map_preg_i;
                state_d     = READ;
            end
            READ: begin
                beat_d.arch = cur_q;
                beat_d.preg = preg_q;
                // x0 is hardwired zero whatever the PRF entry behind it holds
                beat_d.data = (cur_q == '0) ? '0 : prf_rdata_i;
                state_d     = OUT;
            end
            OUT: begin
                if (out_ready_i) begin
                    cur_d   = cur_q + ARCH_W'(1);
                    rem_d   = (rem_q != '0) ? rem_q - (ARCH_W + 1)'(1) : '0;
                    state_d = (rem_q > (ARCH_W + 1)'(1)) ? LOOKUP : FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort wins over everything, including a beat accepted this same cycle
        if (abort_i && (state_q != IDLE)) begin
            state_d = IDLE;
        end
    end

    assign out_valid_o = (state_q == OUT);
    assign out_arch_o  = beat_q.arch;
    assign out_preg_o  = beat_q.preg;
    assign out_data_o  = beat_q.data;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == FIN);

`ifdef DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum_q <= '0;
        end else if (start_accept) begin
            csum_q <= '0;
        end else if (beat_accept) begin
            csum_q <= rotl1(csum_q) ^ beat_q.data;
        end
    end

    assign checksum_o = csum_q;
`else
    logic unused_accept;
    assign unused_accept = start_accept ^ beat_accept;
`endif

endmodule

// File: tb/tb_arch_reg_dump_unit.sv
// Directed self-checking bench for arch_reg_dump_unit; covers the checksum when
// DUMP_CHECKSUM_EN is defined.
module tb_arch_reg_dump_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [4:0]  first_i;
    logic [5:0]  count_i;
    logic        abort_i;
    logic        rob_empty_i;
    logic [4:0]  map_idx_o;
    logic [6:0]  map_preg_i;
    logic [6:0]  prf_raddr_o;
    logic [31:0] prf_rdata_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [4:0]  out_arch_o;
    logic [6:0]  out_preg_o;
    logic [31:0] out_data_o;
    logic        busy_o;
    logic        done_o;
`ifdef DUMP_CHECKSUM_EN
    logic [31:0] checksum_o;
`endif

    logic [6:0]  map_mem [32];
    logic [31:0] prf_mem [128];

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int hs_cnt = 0;

    always #5 clk = ~clk;

    arch_reg_dump_unit dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start_i),
        .first_i     (first_i),
        .count_i     (count_i),
        .abort_i     (abort_i),
        .rob_empty_i (rob_empty_i),
        .map_idx_o   (map_idx_o),
        .map_preg_i  (map_preg_i),
        .prf_raddr_o (prf_raddr_o),
        .prf_rdata_i (prf_rdata_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_arch_o  (out_arch_o),
        .out_preg_o  (out_preg_o),
        .out_data_o  (out_data_o),
        .busy_o      (busy_o),
`ifdef DUMP_CHECKSUM_EN
        .done_o      (done_o),
        .checksum_o  (checksum_o)
`else
        .done_o      (done_o)
`endif
    );

    // Rename map answers combinationally; PRF has one cycle of read latency
    assign map_preg_i = map_mem[map_idx_o];
    always @(posedge clk) prf_rdata_i <= prf_mem[prf_raddr_o];

    always @(posedge clk) begin
        if (done_o) done_cnt++;
        if (out_valid_o && out_ready_i) hs_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_dump(input logic [4:0] f, input logic [5:0] c);
        start_i = 1'b1;
        first_i = f;
        count_i = c;
        tick();
        start_i = 1'b0;
    endtask

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        return (a == 5'd0) ? 32'h0 : prf_mem[map_mem[a]];
    endfunction

    task automatic wait_valid();
        int n = 0;
        while (!out_valid_o && n < 20) begin
            tick();
            n++;
        end
        check("beat_valid", 64'(out_valid_o), 64'd1);
    endtask

    // Expects one beat for arch a and accepts it (out_ready_i must be 1)
    task automatic get_beat(input logic [4:0] a);
        wait_valid();
        check("beat_arch", 64'(out_arch_o), 64'(a));
        check("beat_preg", 64'(out_preg_o), 64'(map_mem[a]));
        check("beat_data", 64'(out_data_o), 64'(exp_data(a)));
        tick();
    endtask

    initial begin
        int d0;
        int h0;

        for (int a = 0; a < 32; a++) map_mem[a] = 7'(a + 32);
        for (int p = 0; p < 128; p++) prf_mem[p] = 32'hC0DE_0000 | 32'(p);
        prf_mem[42] = 32'h0000_0005;
        prf_mem[32] = 32'hDEAD_BEEF;

        reset       = 1'b1;
        start_i     = 1'b0;
        first_i     = '0;
        count_i     = '0;
        abort_i     = 1'b0;
        rob_empty_i = 1'b1;
        out_ready_i = 1'b1;
        tick();
        tick();
        check("rst_valid", 64'(out_valid_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_fields", {out_arch_o, out_preg_o, out_data_o}, 64'd0);
        check("rst_addrs", {map_idx_o, prf_raddr_o}, 64'd0);
`ifdef DUMP_CHECKSUM_EN
        check("rst_checksum", 64'(checksum_o), 64'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Single register with exact pipeline timing
        d0 = done_cnt;
        h0 = hs_cnt;
        start_dump(5'd10, 6'd1);
        check("t1_busy_waitq", 64'(busy_o), 64'd1);
        check("t1_valid_waitq", 64'(out_valid_o), 64'd0);
        tick();
        check("t1_map_idx", 64'(map_idx_o), 64'd10);
        check("t1_prf_raddr", 64'(prf_raddr_o), 64'd42);
        tick();
        check("t1_valid_read", 64'(out_valid_o), 64'd0);
        tick();
        check("t1_valid_out", 64'(out_valid_o), 64'd1);
        check("t1_arch", 64'(out_arch_o), 64'd10);
        check("t1_preg", 64'(out_preg_o), 64'd42);
        check("t1_data", 64'(out_data_o), 64'h5);
        tick();
        check("t1_done", 64'(done_o), 64'd1);
        check("t1_valid_fin", 64'(out_valid_o), 64'd0);
        tick();
        check("t1_done_low", 64'(done_o), 64'd0);
        check("t1_idle", 64'(busy_o), 64'd0);
        check("t1_done_cnt", 64'(done_cnt - d0), 64'd1);
        check("t1_hs_cnt", 64'(hs_cnt - h0), 64'd1);

        // Full dump; x0 reads as zero despite PRF[32]=DEADBEEF
        d0 = done_cnt;
        h0 = hs_cnt;
        start_dump(5'd0, 6'd0);
        for (int i = 0; i < 32; i++) get_beat(5'(i));
        check("t2_done", 64'(done_o), 64'd1);
        tick();
        check("t2_hs_cnt", 64'(hs_cnt - h0), 64'd32);
        check("t2_done_cnt", 64'(done_cnt - d0), 64'd1);
        check("t2_idle", 64'(busy_o), 64'd0);

        // Wrapping window; a start while busy must be ignored
        d0 = done_cnt;
        start_dump(5'd30, 6'd4);
        start_i = 1'b1;
        first_i = 5'd15;
        count_i = 6'd1;
        get_beat(5'd30);
        start_i = 1'b0;
        get_beat(5'd31);
        get_beat(5'd0);
        check("t3_no_early_done", 64'(done_cnt - d0), 64'd0);
        get_beat(5'd1);
        check("t3_done", 64'(done_o), 64'd1);
        tick();
        check("t3_done_cnt", 64'(done_cnt - d0), 64'd1);

        // Backpressure: fields hold while ready is low
        h0 = hs_cnt;
        out_ready_i = 1'b0;
        start_dump(5'd5, 6'd1);
        wait_valid();
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t4_hold_valid", 64'(out_valid_o), 64'd1);
            check("t4_hold_fields", {out_arch_o, out_preg_o, out_data_o},
                  {5'd5, 7'd37, 32'hC0DE_0025});
        end
        check("t4_no_hs", 64'(hs_cnt - h0), 64'd0);
        out_ready_i = 1'b1;
        tick();
        check("t4_done", 64'(done_o), 64'd1);
        tick();
        check("t4_hs_cnt", 64'(hs_cnt - h0), 64'd1);

        // Quiesce: nothing happens until the ROB drains
        rob_empty_i = 1'b0;
        start_dump(5'd3, 6'd1);
        for (int k = 0; k < 10; k++) begin
            check("t5_busy", 64'(busy_o), 64'd1);
            check("t5_no_valid", 64'(out_valid_o), 64'd0);
            tick();
        end
        rob_empty_i = 1'b1;
        tick();
        check("t5_lookup_idx", 64'(map_idx_o), 64'd3);
        tick();
        tick();
        check("t5_valid_latency", 64'(out_valid_o), 64'd1);
        get_beat(5'd3);
        tick();

        // Abort between beats
        d0 = done_cnt;
        start_dump(5'd0, 6'd0);
        get_beat(5'd0);
        get_beat(5'd1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("t6_idle", 64'(busy_o), 64'd0);
        check("t6_no_valid", 64'(out_valid_o), 64'd0);
        tick();
        tick();
        check("t6_no_done", 64'(done_cnt - d0), 64'd0);

        // Abort coincident with a handshake: beat transfers, abort still wins
        d0 = done_cnt;
        h0 = hs_cnt;
        start_dump(5'd20, 6'd3);
        wait_valid();
        check("t6b_arch", 64'(out_arch_o), 64'd20);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("t6b_idle", 64'(busy_o), 64'd0);
        check("t6b_hs", 64'(hs_cnt - h0), 64'd1);
        tick();
        tick();
        check("t6b_no_done", 64'(done_cnt - d0), 64'd0);

`ifdef DUMP_CHECKSUM_EN
        prf_mem[42] = 32'h0000_0001;
        prf_mem[43] = 32'h0000_0002;
        start_dump(5'd10, 6'd1);
        get_beat(5'd10);
        check("cs_one_done", 64'(done_o), 64'd1);
        check("cs_one", 64'(checksum_o), 64'h1);
        tick();
        start_dump(5'd10, 6'd2);
        check("cs_cleared", 64'(checksum_o), 64'h0);
        get_beat(5'd10);
        get_beat(5'd11);
        check("cs_two_done", 64'(done_o), 64'd1);
        check("cs_two", 64'(checksum_o), 64'h0);
        tick();
`endif

        // Asynchronous reset mid-dump clears outputs without a clock edge
        start_dump(5'd7, 6'd2);
        wait_valid();
        check("t7_arch_pre", 64'(out_arch_o), 64'd7);
        #2;
        reset = 1'b1;
        #1;
        check("t7_valid", 64'(out_valid_o), 64'd0);
        check("t7_busy", 64'(busy_o), 64'd0);
        check("t7_fields", {out_arch_o, out_preg_o, out_data_o}, 64'd0);
        check("t7_addrs", {map_idx_o, prf_raddr_o, done_o}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("t7_idle_after", 64'(busy_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
